// File: rtl/data_mem_io_if.sv
// Data-side bus between the single-cycle core and data_mem_io.
// Address and write data come from the core; ReadData returns combinationally in the same cycle.
interface data_mem_io_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output Mem_WrAddr,
        output Mem_WrData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  Mem_WrAddr,
        input  Mem_WrData,
        output ReadData
    );
endinterface

// File: rtl/data_mem_io.sv
// data_mem_io: word RAM, UART transmitter with TX FIFO and a free-running cycle counter on the core data bus.
// Build macro UART_PARITY_EN adds an even-parity bit to every UART frame and sets STATUS bit 4.
//
// state    | meaning
// S_IDLE   | line high, waiting for a byte in the FIFO
// S_START  | start bit (line low)
// S_DATA   | 8 data bits, LSB first
// S_PARITY | even parity bit (UART_PARITY_EN builds only)
// S_STOP   | stop bit (line high); chains straight into the next frame if the FIFO has data
module data_mem_io #(
    parameter int          RAM_AW       = 10,
    parameter logic [31:0] RAM_BASE     = 32'h0000_2000,
    parameter logic [31:0] IO_BASE      = 32'h0000_3000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    data_mem_io_if.slave bus,
    output logic         uart_tx,
    output logic         tx_busy
);
    localparam int                  FIFO_AW     = $clog2(FIFO_DEPTH);
    localparam int                  BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]   BAUD_ONE    = BAUD_W'(1);
    localparam logic [FIFO_AW:0]    PTR_ONE     = (FIFO_AW + 1)'(1);
    localparam logic [31:0]         RAM_BYTES   = 32'(4 << RAM_AW);
    localparam logic [31:0]         ADDR_TXDATA = IO_BASE;
    localparam logic [31:0]         ADDR_STATUS = IO_BASE + 32'd4;
    localparam logic [31:0]         ADDR_CYCLE  = IO_BASE + 32'd8;

`ifdef UART_PARITY_EN
    localparam logic PARITY_BUILD = 1'b1;
`else
    localparam logic PARITY_BUILD = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    logic [31:0]        word_addr;
    logic [31:0]        ram_off;
    logic [RAM_AW-1:0]  ram_idx;
    logic               ram_hit;
    logic               txdata_hit;
    logic               status_hit;
    logic               cycle_hit;
    logic               wr_ram;
    logic               wr_txdata;
    logic               wr_status;
    logic               wr_cycle;

    logic [31:0]        ram [2**RAM_AW];
    logic [31:0]        cycle_cnt;
    logic               overflow;
    logic [31:0]        status_word;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         fifo_rd_data;

    tx_state_t          state;
    tx_state_t          state_n;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BAUD_W-1:0]  baud_cnt_n;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_n;
    logic [7:0]         tx_shreg;
    logic [7:0]         tx_shreg_n;
    logic               baud_tc;

    // ---------------------------------------------------------------- decode
    assign word_addr  = bus.Mem_WrAddr & ~32'h3;
    assign ram_off    = word_addr - RAM_BASE;
    assign ram_hit    = (word_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
    assign ram_idx    = ram_off[RAM_AW+1:2];
    assign txdata_hit = (word_addr == ADDR_TXDATA);
    assign status_hit = (word_addr == ADDR_STATUS);
    assign cycle_hit  = (word_addr == ADDR_CYCLE);

    assign wr_ram     = bus.MemWrite && ram_hit;
    assign wr_txdata  = bus.MemWrite && txdata_hit;
    assign wr_status  = bus.MemWrite && status_hit;
    assign wr_cycle   = bus.MemWrite && cycle_hit;

    assign status_word = {27'b0, PARITY_BUILD, overflow, fifo_empty, fifo_full, tx_busy};

    always_comb begin
        bus.ReadData = 32'h0000_0000;
        if (ram_hit) begin
            bus.ReadData = ram[ram_idx];
        end else if (status_hit) begin
            bus.ReadData = status_word;
        end else if (cycle_hit) begin
            bus.ReadData = cycle_cnt;
        end
    end

    // ---------------------------------------------------------------- RAM (never cleared)
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= bus.Mem_WrData;
        end
    end

    // ---------------------------------------------------------------- cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'h0;
        end else if (wr_cycle) begin
            cycle_cnt <= bus.Mem_WrData;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                          (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign fifo_push    = wr_txdata && !fifo_full;
    assign fifo_rd_data = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= bus.Mem_WrData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // A same-cycle clear loses to a new overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            overflow <= 1'b1;
        end else if (wr_status && bus.Mem_WrData[3]) begin
            overflow <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- TX FSM
    assign baud_tc = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_shreg <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            tx_shreg <= tx_shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        tx_shreg_n = tx_shreg;
        fifo_pop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shreg_n = fifo_rd_data;
                    baud_cnt_n = BAUD_RELOAD;
                    state_n    = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    baud_cnt_n = BAUD_RELOAD;
                    bit_idx_n  = 3'd0;
                    state_n    = S_DATA;
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_cnt_n = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    baud_cnt_n = BAUD_RELOAD;
                    state_n    = S_STOP;
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shreg_n = fifo_rd_data;
                        baud_cnt_n = BAUD_RELOAD;
                        state_n    = S_START;
                    end else begin
                        state_n    = S_IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - BAUD_ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state)
            S_START:  uart_tx = 1'b0;
            S_DATA:   uart_tx = tx_shreg[bit_idx];
            S_PARITY: uart_tx = ^tx_shreg;
            default:  uart_tx = 1'b1;
        endcase
    end

    assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: table-driven bus vectors, hand sequences for UART timing,
// and a serial-line monitor that checks transmitted bytes against a scoreboard queue.
module tb_data_mem_io;
    localparam int          CPB     = 4;
    localparam logic [31:0] IO_BASE = 32'h0000_3000;
`ifdef UART_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam logic [31:0] ST_PAR     = 32'h10;
`else
    localparam int          FRAME_BITS = 10;
    localparam logic [31:0] ST_PAR     = 32'h0;
`endif
    localparam int          FRAME_CLKS = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;
    logic tx_busy;

    data_mem_io_if bus ();

    data_mem_io dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] sb_q[$];
    bit         mon_en  = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.MemWrite   = 1'b0;
        bus.Mem_WrAddr = addr;
        #1;
        data = bus.ReadData;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite   = 1'b1;
        bus.Mem_WrAddr = addr;
        bus.Mem_WrData = data;
        @(posedge clk);
        #1;
        bus.MemWrite   = 1'b0;
    endtask

    task automatic wr_tx(input logic [7:0] b, input bit expect_sent);
        if (expect_sent) sb_q.push_back(b);
        wr(IO_BASE, {24'h0, b});
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            rd(IO_BASE + 32'd4, st);
            if (st[0] == 1'b0 && st[2] == 1'b1) ok = 1'b1;
            else tick();
        end
        check({name, "_idle_wait"}, {31'h0, ok}, 32'h1);
        tick();
    endtask

    // Serial monitor: decodes frames at mid-bit and compares with the scoreboard.
    initial begin
        logic [7:0] b;
        logic       start_b;
        logic       stop_b;
        logic       par_b;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && uart_tx === 1'b0) begin
                repeat (2) @(negedge clk);
                start_b = uart_tx;
                repeat (3) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = uart_tx;
                    if (i < 7) repeat (4) @(negedge clk);
                end
                par_b = 1'b0;
`ifdef UART_PARITY_EN
                repeat (4) @(negedge clk);
                par_b = uart_tx;
`endif
                repeat (4) @(negedge clk);
                stop_b = uart_tx;
                check("uart_start_bit", {31'h0, start_b}, 32'h0);
                check("uart_stop_bit", {31'h0, stop_b}, 32'h1);
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL uart_unexpected_frame: got byte %h expected none", b);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("uart_byte", {24'h0, b}, {24'h0, exp_b});
`ifdef UART_PARITY_EN
                    check("uart_parity", {31'h0, par_b}, {31'h0, ^exp_b});
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        exp_bits[FRAME_BITS];
        logic [7:0]  d55;
        int          errs;

        bus.MemWrite   = 1'b0;
        bus.Mem_WrAddr = 32'h0;
        bus.Mem_WrData = 32'h0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        rd(IO_BASE + 32'd4, r); check("rst_status", r, ST_PAR | 32'h4);
        rd(IO_BASE + 32'd8, r); check("rst_cycle", r, 32'h0);

        // Cycle counter: count, load, wrap
        repeat (5) tick();
        rd(IO_BASE + 32'd8, r); check("cycle_at_5", r, 32'd5);
        wr(IO_BASE + 32'd8, 32'hFFFF_FFFE);
        rd(IO_BASE + 32'd8, r); check("cycle_load", r, 32'hFFFF_FFFE);
        tick();
        rd(IO_BASE + 32'd8, r); check("cycle_max", r, 32'hFFFF_FFFF);
        tick();
        rd(IO_BASE + 32'd8, r); check("cycle_wrap", r, 32'h0);

        mon_en = 1'b1;

        // Table-driven bus vectors
        vecs.push_back('{1'b1, 32'h2004, 32'hDEAD_BEEF, 32'h0, "ram_w_2004"});
        vecs.push_back('{1'b0, 32'h2004, 32'h0, 32'hDEAD_BEEF, "ram_r_2004"});
        vecs.push_back('{1'b1, 32'h2008, 32'h1234_5678, 32'h0, "ram_w_2008"});
        vecs.push_back('{1'b0, 32'h2008, 32'h0, 32'h1234_5678, "ram_r_2008"});
        vecs.push_back('{1'b0, 32'h2006, 32'h0, 32'hDEAD_BEEF, "ram_r_lowbits"});
        vecs.push_back('{1'b1, 32'h2000, 32'h0BAD_F00D, 32'h0, "ram_w_first"});
        vecs.push_back('{1'b0, 32'h2000, 32'h0, 32'h0BAD_F00D, "ram_r_first"});
        vecs.push_back('{1'b1, 32'h2FFC, 32'hCAFE_F00D, 32'h0, "ram_w_last"});
        vecs.push_back('{1'b0, 32'h2FFC, 32'h0, 32'hCAFE_F00D, "ram_r_last"});
        vecs.push_back('{1'b1, 32'h1FFC, 32'hFFFF_FFFF, 32'h0, "unmapped_w_below"});
        vecs.push_back('{1'b0, 32'h1FFC, 32'h0, 32'h0, "unmapped_r_below"});
        vecs.push_back('{1'b0, 32'h2FFC, 32'h0, 32'hCAFE_F00D, "ram_last_no_alias"});
        vecs.push_back('{1'b0, 32'h4000, 32'h0, 32'h0, "unmapped_r_4000"});
        vecs.push_back('{1'b0, 32'h300C, 32'h0, 32'h0, "unmapped_r_300c"});
        vecs.push_back('{1'b0, 32'h3000, 32'h0, 32'h0, "txdata_reads_0"});
        vecs.push_back('{1'b1, 32'h3004, 32'h8, 32'h0, "status_clr_idle"});
        vecs.push_back('{1'b0, 32'h3004, 32'h0, ST_PAR | 32'h4, "status_idle"});

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr, r);
                check(vecs[i].name, r, vecs[i].exp);
                tick();
            end
        end

        // RAM survives reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(32'h2008, r); check("ram_keep_2008", r, 32'h1234_5678);
        rd(32'h2004, r); check("ram_keep_2004", r, 32'hDEAD_BEEF);
        tick();

        // Single frame 0x55 with exact line timing
        d55 = 8'h55;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d55[i];
`ifdef UART_PARITY_EN
        exp_bits[9] = ^d55;
`endif
        exp_bits[FRAME_BITS-1] = 1'b1;
        wr_tx(8'h55, 1'b1);
        check("f55_busy_before", {31'h0, tx_busy}, 32'h0);
        tick();
        errs = 0;
        for (int c = 0; c < FRAME_CLKS; c++) begin
            if (uart_tx !== exp_bits[c / CPB] || tx_busy !== 1'b1) errs++;
            tick();
        end
        check("f55_line_errors", errs, 32'h0);
        check("f55_busy_after", {31'h0, tx_busy}, 32'h0);
        check("f55_idle_line", {31'h0, uart_tx}, 32'h1);
        wait_idle("f55");

        // Back-to-back frames: no idle clock between them
        wr_tx(8'hA5, 1'b1);
        wr_tx(8'h3C, 1'b1);
        errs = 0;
        for (int c = 0; c < 2 * FRAME_CLKS; c++) begin
            if (tx_busy !== 1'b1) errs++;
            if (c == FRAME_CLKS - 1) check("b2b_stop1", {31'h0, uart_tx}, 32'h1);
            if (c == FRAME_CLKS)     check("b2b_start2", {31'h0, uart_tx}, 32'h0);
            tick();
        end
        check("b2b_busy_gap", errs, 32'h0);
        check("b2b_busy_end", {31'h0, tx_busy}, 32'h0);
        wait_idle("b2b");

        // FIFO overflow
        for (int i = 0; i < 9; i++) wr_tx(8'h10 + 8'(i), 1'b1);
        rd(IO_BASE + 32'd4, r); check("ovf_status_full", r, ST_PAR | 32'h3);
        wr_tx(8'hEE, 1'b0);
        rd(IO_BASE + 32'd4, r); check("ovf_status_set", r, ST_PAR | 32'hB);
        wr(IO_BASE + 32'd4, 32'h8);
        rd(IO_BASE + 32'd4, r); check("ovf_status_clr", r, ST_PAR | 32'h3);
        tick();
        wait_idle("ovf");
        check("ovf_sb_drained", sb_q.size(), 32'h0);

        // Reset in the middle of a frame
        mon_en = 1'b0;
        wr_tx(8'hFF, 1'b0);
        wr_tx(8'h11, 1'b0);
        wr_tx(8'h22, 1'b0);
        repeat (15) tick();
        check("midrst_busy_pre", {31'h0, tx_busy}, 32'h1);
        check("midrst_line_pre", {31'h0, uart_tx}, 32'h1);
        rd(IO_BASE + 32'd4, r); check("midrst_status_pre", r, ST_PAR | 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_line", {31'h0, uart_tx}, 32'h1);
        check("midrst_busy", {31'h0, tx_busy}, 32'h0);
        rd(IO_BASE + 32'd4, r); check("midrst_status", r, ST_PAR | 32'h4);
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (tx_busy !== 1'b0 || uart_tx !== 1'b1) errs++;
        end
        check("midrst_no_frames", errs, 32'h0);
        mon_en = 1'b1;

        check("sb_final_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
